// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and types for the MEM pipeline stage.
//   - RV32I load/store FUNCT3 encodings
//   - MemtoReg write-back source codes
//   - MEM FSM state type
//   - is_misaligned(): access alignment rule used by the byte-lane aligner
package mem_stage_pkg;

  // Load encodings; store encodings share the low two bits (size).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Write-back source select.
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } mem_state_e;

  // Halfwords need an even address, words a multiple of four; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: mis = off[0];
      F3_LW:         mis = |off;
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational byte-lane alignment for the MEM stage.
//   funct3     - RV32I load/store width/sign encoding
//   addr_lo    - byte offset within the word
//   store_data - raw store operand (rs2)
//   rdata      - raw word read from data memory
//   be         - store byte enables
//   wdata      - store data replicated across lanes
//   load_data  - extracted, sign/zero-extended load result
//   misalign   - access violates its natural alignment
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] lane;

  // Move the addressed byte/half down to bit 0.
  assign lane     = rdata >> {addr_lo, 3'b000};
  assign misalign = is_misaligned(funct3, addr_lo);

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (funct3)
      F3_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_SH: begin
        be    = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = lane;
    case (funct3)
      F3_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
      F3_LBU:  load_data = {24'h0, lane[7:0]};
      F3_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
      F3_LHU:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I MEM pipeline stage with a simple request/ack data-memory bus.
//   CLK, RST        - clock, asynchronous active-low reset
//   *_EM            - EX/MEM pipeline inputs (held stable by upstream while STALL_MEM=1)
//   DMEM_*          - data-memory bus (REQ held with stable address/data until ACK)
//   *_MW            - registered MEM/WB outputs; MISALIGN_MW flags an alignment exception
//   STALL_MEM       - freeze upstream while a request waits for ACK
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        VALID_EM,
  input  logic [31:0] ALU_RES_EM,
  input  logic [31:0] RS2_VAL_EM,
  input  logic [31:0] PC4_EM,
  input  logic [4:0]  RD_EM,
  input  logic [1:0]  MemtoReg_EM,
  input  logic        RegWrite_EM,
  input  logic        MemRead_EM,
  input  logic        MemWrite_EM,
  input  logic [2:0]  FUNCT3_EM,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        VALID_MW,
  output logic [31:0] MEM_DATA_MW,
  output logic [31:0] PC4_MW,
  output logic [4:0]  RD_MW,
  output logic [1:0]  MemtoReg_MW,
  output logic        RegWrite_MW,
  output logic        STALL_MEM,
  output logic        MISALIGN_MW
);

  mem_state_e  state_q;
  logic        mem_op;
  logic        misalign;
  logic        mis_op;
  logic [31:0] load_data;

  lsu_align u_lsu_align (
    .funct3     (FUNCT3_EM),
    .addr_lo    (ALU_RES_EM[1:0]),
    .store_data (RS2_VAL_EM),
    .rdata      (DMEM_RDATA),
    .be         (DMEM_BE),
    .wdata      (DMEM_WDATA),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  assign mem_op = VALID_EM & (MemRead_EM | MemWrite_EM);
  // Alignment only matters for real memory ops; ALU ops may carry any funct3.
  assign mis_op = mem_op & misalign;

  // Gated by RST so nothing is requested while reset is held.
  assign DMEM_REQ  = RST & ((state_q == StWait) | (mem_op & ~misalign));
  assign STALL_MEM = DMEM_REQ & ~DMEM_ACK;
  assign DMEM_ADDR = {ALU_RES_EM[31:2], 2'b00};
  assign DMEM_WE   = MemWrite_EM;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      VALID_MW    <= 1'b0;
      MEM_DATA_MW <= 32'h0;
      PC4_MW      <= 32'h0;
      RD_MW       <= 5'h0;
      MemtoReg_MW <= 2'b00;
      RegWrite_MW <= 1'b0;
      MISALIGN_MW <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  if (DMEM_REQ && !DMEM_ACK) state_q <= StWait;
        StWait:  if (DMEM_ACK) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (STALL_MEM || !VALID_EM) begin
        // Bubble; data fields keep their last value and are qualified by VALID_MW.
        VALID_MW    <= 1'b0;
        RegWrite_MW <= 1'b0;
        MISALIGN_MW <= 1'b0;
      end else begin
        VALID_MW    <= 1'b1;
        MEM_DATA_MW <= (MemtoReg_EM == MTR_MEM) ? load_data : ALU_RES_EM;
        PC4_MW      <= PC4_EM;
        RD_MW       <= RD_EM;
        MemtoReg_MW <= MemtoReg_EM;
        RegWrite_MW <= RegWrite_EM & (RD_EM != 5'd0) & ~mis_op;
        MISALIGN_MW <= mis_op;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        VALID_EM;
  logic [31:0] ALU_RES_EM, RS2_VAL_EM, PC4_EM;
  logic [4:0]  RD_EM;
  logic [1:0]  MemtoReg_EM;
  logic        RegWrite_EM, MemRead_EM, MemWrite_EM;
  logic [2:0]  FUNCT3_EM;
  logic        DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_ACK;
  logic        VALID_MW;
  logic [31:0] MEM_DATA_MW, PC4_MW;
  logic [4:0]  RD_MW;
  logic [1:0]  MemtoReg_MW;
  logic        RegWrite_MW, STALL_MEM, MISALIGN_MW;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .CLK         (CLK),
    .RST         (RST),
    .VALID_EM    (VALID_EM),
    .ALU_RES_EM  (ALU_RES_EM),
    .RS2_VAL_EM  (RS2_VAL_EM),
    .PC4_EM      (PC4_EM),
    .RD_EM       (RD_EM),
    .MemtoReg_EM (MemtoReg_EM),
    .RegWrite_EM (RegWrite_EM),
    .MemRead_EM  (MemRead_EM),
    .MemWrite_EM (MemWrite_EM),
    .FUNCT3_EM   (FUNCT3_EM),
    .DMEM_REQ    (DMEM_REQ),
    .DMEM_WE     (DMEM_WE),
    .DMEM_ADDR   (DMEM_ADDR),
    .DMEM_WDATA  (DMEM_WDATA),
    .DMEM_BE     (DMEM_BE),
    .DMEM_RDATA  (DMEM_RDATA),
    .DMEM_ACK    (DMEM_ACK),
    .VALID_MW    (VALID_MW),
    .MEM_DATA_MW (MEM_DATA_MW),
    .PC4_MW      (PC4_MW),
    .RD_MW       (RD_MW),
    .MemtoReg_MW (MemtoReg_MW),
    .RegWrite_MW (RegWrite_MW),
    .STALL_MEM   (STALL_MEM),
    .MISALIGN_MW (MISALIGN_MW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] pc4,
                        input logic [4:0] rd, input logic [1:0] mtr, input logic rw);
    VALID_EM    = v;
    MemRead_EM  = rd_en;
    MemWrite_EM = wr_en;
    FUNCT3_EM   = f3;
    ALU_RES_EM  = addr;
    RS2_VAL_EM  = rs2;
    PC4_EM      = pc4;
    RD_EM       = rd;
    MemtoReg_EM = mtr;
    RegWrite_EM = rw;
  endtask

  // Called just after a negedge with inputs applied; returns 1ns after the completing edge.
  task automatic run_txn(input int dly, input logic exp_req);
    for (int k = 0; k <= dly; k++) begin
      DMEM_ACK = exp_req ? (k == dly) : 1'($urandom_range(0, 1));
      #1;
      chk("dmem_req", {31'h0, DMEM_REQ}, {31'h0, exp_req});
      chk("stall", {31'h0, STALL_MEM}, {31'h0, exp_req && (k < dly)});
      @(posedge CLK);
      #1;
      if (k < dly) begin
        chk("stall_bubble", {31'h0, VALID_MW}, 32'h0);
        @(negedge CLK);
      end
    end
  endtask

  // ---------------- reference model (from the access rules) ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr % 4) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int v;
    v = ((1 << nbytes(f3)) - 1) << int'(addr % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    if (nbytes(f3) == 1) return (rs2 % 256) * 32'h01010101;
    if (nbytes(f3) == 2) return (rs2 % 65536) * 32'h00010001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    longint v, span;
    int n;
    n = nbytes(f3);
    if (n == 4) return rdata;
    span = 64'd1 << (8 * n);
    v = (longint'(rdata) / (64'd1 << (8 * int'(addr % 4)))) % span;
    if (f3 < 3'd4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  typedef struct {
    logic [2:0]  f3;
    logic        st;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        mis;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata, pc4;
    logic [4:0]  rd;
    logic [1:0]  mtr;
    logic        v, ld, st, rw, mis, ereq;
    int          kind, dly;
    logic [2:0]  ld_codes[5];
    logic [31:0] exp_data;

    ld_codes[0] = F3_LB;  ld_codes[1] = F3_LH; ld_codes[2] = F3_LW;
    ld_codes[3] = F3_LBU; ld_codes[4] = F3_LHU;

    vecs[0]  = '{F3_SB,  1'b1, 32'h103, 32'h000000AB, 32'h0, 4'b1000, 32'hABABABAB, 32'h103, 1'b0};
    vecs[1]  = '{F3_SH,  1'b1, 32'h102, 32'h1234ABCD, 32'h0, 4'b1100, 32'hABCDABCD, 32'h102, 1'b0};
    vecs[2]  = '{F3_SW,  1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h100, 1'b0};
    vecs[3]  = '{F3_SB,  1'b1, 32'h201, 32'h00000F5C, 32'h0, 4'b0010, 32'h5C5C5C5C, 32'h201, 1'b0};
    vecs[4]  = '{F3_LB,  1'b0, 32'h101, 32'h0, 32'h1234F678, 4'b0, 32'h0, 32'hFFFFFFF6, 1'b0};
    vecs[5]  = '{F3_LBU, 1'b0, 32'h101, 32'h0, 32'h1234F678, 4'b0, 32'h0, 32'h000000F6, 1'b0};
    vecs[6]  = '{F3_LH,  1'b0, 32'h102, 32'h0, 32'h80010000, 4'b0, 32'h0, 32'hFFFF8001, 1'b0};
    vecs[7]  = '{F3_LHU, 1'b0, 32'h100, 32'h0, 32'h12349ABC, 4'b0, 32'h0, 32'h00009ABC, 1'b0};
    vecs[8]  = '{F3_LW,  1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 4'b0, 32'h0, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{F3_SW,  1'b1, 32'h102, 32'h11111111, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1};
    vecs[10] = '{F3_LHU, 1'b0, 32'h101, 32'h0, 32'h55667788, 4'b0, 32'h0, 32'h0, 1'b1};

    // Reset state, with a valid aligned load presented.
    DMEM_ACK = 1'b0;
    DMEM_RDATA = 32'h0;
    set_op(1'b1, 1'b1, 1'b0, F3_LW, 32'h40, 32'h0, 32'h4, 5'd3, MTR_MEM, 1'b1);
    #2;
    chk("rst_req", {31'h0, DMEM_REQ}, 32'h0);
    chk("rst_stall", {31'h0, STALL_MEM}, 32'h0);
    chk("rst_valid", {31'h0, VALID_MW}, 32'h0);
    chk("rst_data", MEM_DATA_MW, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    // Table vectors, zero-wait ACK.
    foreach (vecs[i]) begin
      st = vecs[i].st;
      set_op(1'b1, !st, st, vecs[i].f3, vecs[i].addr, vecs[i].rs2, vecs[i].addr + 4,
             st ? 5'd0 : 5'd5, st ? MTR_ALU : MTR_MEM, !st);
      DMEM_RDATA = vecs[i].rdata;
      #1;
      chk("vec_addr", DMEM_ADDR, vecs[i].addr & 32'hFFFFFFFC);
      if (st && !vecs[i].mis) begin
        chk("vec_be", {28'h0, DMEM_BE}, {28'h0, vecs[i].be});
        chk("vec_wdata", DMEM_WDATA, vecs[i].wdata);
        chk("vec_we", {31'h0, DMEM_WE}, 32'h1);
      end
      run_txn(0, !vecs[i].mis);
      chk("vec_valid", {31'h0, VALID_MW}, 32'h1);
      chk("vec_mis", {31'h0, MISALIGN_MW}, {31'h0, vecs[i].mis});
      chk("vec_rw", {31'h0, RegWrite_MW}, {31'h0, !st && !vecs[i].mis});
      if (!vecs[i].mis) chk("vec_data", MEM_DATA_MW, vecs[i].data);
      @(negedge CLK);
    end

    // LB with ACK three cycles late: three stall cycles.
    set_op(1'b1, 1'b1, 1'b0, F3_LB, 32'h102, 32'h0, 32'h58, 5'd7, MTR_MEM, 1'b1);
    DMEM_RDATA = 32'h00800000;
    run_txn(3, 1'b1);
    chk("lb_wait_data", MEM_DATA_MW, 32'hFFFFFF80);
    chk("lb_wait_mtr", {30'h0, MemtoReg_MW}, {30'h0, MTR_MEM});
    chk("lb_wait_valid", {31'h0, VALID_MW}, 32'h1);
    @(negedge CLK);

    // JAL: no memory access, PC+4 passes through.
    set_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h1000, 32'h0, 32'h44, 5'd1, MTR_PC4, 1'b1);
    run_txn(0, 1'b0);
    chk("jal_pc4", PC4_MW, 32'h44);
    chk("jal_rd", {27'h0, RD_MW}, 32'h1);
    chk("jal_rw", {31'h0, RegWrite_MW}, 32'h1);
    @(negedge CLK);

    // Write to x0 must not assert RegWrite_MW.
    set_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 32'h48, 5'd0, MTR_ALU, 1'b1);
    run_txn(0, 1'b0);
    chk("x0_rw", {31'h0, RegWrite_MW}, 32'h0);
    @(negedge CLK);

    // LW in WAIT, reset for one cycle, late ACK afterwards.
    set_op(1'b1, 1'b1, 1'b0, F3_LW, 32'h300, 32'h0, 32'h304, 5'd9, MTR_MEM, 1'b1);
    DMEM_RDATA = 32'h12345678;
    DMEM_ACK = 1'b0;
    #1;
    chk("rw_req", {31'h0, DMEM_REQ}, 32'h1);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rw_rst_req", {31'h0, DMEM_REQ}, 32'h0);
    chk("rw_rst_stall", {31'h0, STALL_MEM}, 32'h0);
    chk("rw_rst_data", MEM_DATA_MW, 32'h0);
    chk("rw_rst_pc4", PC4_MW, 32'h0);
    chk("rw_rst_rd", {27'h0, RD_MW}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, MTR_ALU, 1'b0);
    #1;
    chk("rw_idle_req", {31'h0, DMEM_REQ}, 32'h0);
    @(negedge CLK);
    DMEM_ACK = 1'b1;
    #1;
    chk("rw_late_req", {31'h0, DMEM_REQ}, 32'h0);
    chk("rw_late_stall", {31'h0, STALL_MEM}, 32'h0);
    @(posedge CLK);
    #1;
    chk("rw_late_valid", {31'h0, VALID_MW}, 32'h0);
    chk("rw_late_data", MEM_DATA_MW, 32'h0);
    @(negedge CLK);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 300; n++) begin
      kind  = int'($urandom_range(0, 3));
      v     = ($urandom_range(0, 7) != 0);
      addr  = $urandom;
      rs2   = $urandom;
      rdata = $urandom;
      pc4   = $urandom;
      rd    = 5'($urandom_range(0, 31));
      ld    = (kind == 2);
      st    = (kind == 3);
      if (ld) f3 = ld_codes[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 2));
      mtr   = ld ? MTR_MEM : (kind == 1 ? MTR_PC4 : MTR_ALU);
      rw    = !st;
      mis   = (ld || st) && m_mis(f3, addr);
      ereq  = v && (ld || st) && !mis;
      dly   = ereq ? int'($urandom_range(0, 3)) : 0;
      set_op(v, ld, st, f3, addr, rs2, pc4, rd, mtr, rw);
      DMEM_RDATA = rdata;
      #1;
      if (ereq) chk("rnd_addr", DMEM_ADDR, addr - (addr % 4));
      if (ereq && st) begin
        chk("rnd_be", {28'h0, DMEM_BE}, {28'h0, m_be(f3, addr)});
        chk("rnd_wdata", DMEM_WDATA, m_wdata(f3, rs2));
      end
      run_txn(dly, ereq);
      chk("rnd_valid", {31'h0, VALID_MW}, {31'h0, v});
      chk("rnd_mis", {31'h0, MISALIGN_MW}, {31'h0, v && mis});
      chk("rnd_rw", {31'h0, RegWrite_MW}, {31'h0, v && rw && (rd != 0) && !mis});
      if (v) begin
        chk("rnd_rd", {27'h0, RD_MW}, {27'h0, rd});
        chk("rnd_pc4", PC4_MW, pc4);
        chk("rnd_mtr", {30'h0, MemtoReg_MW}, {30'h0, mtr});
        exp_data = ld ? m_load(f3, addr, rdata) : addr;
        if (!mis) chk("rnd_data", MEM_DATA_MW, exp_data);
      end
      @(negedge CLK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: CLK  input  1  rising-edge clock; RST  input  1  asynchronous active-low reset (0 = reset).
REQ-002 SHALL have EX/MEM inputs: VALID_EM 1, ALU_RES_EM 32 (address or result), RS2_VAL_EM 32 (store data), PC4_EM 32, RD_EM 5, MemtoReg_EM 2, RegWrite_EM 1, MemRead_EM 1, MemWrite_EM 1, FUNCT3_EM 3 (RV32I load/store width).
REQ-003 SHALL have data-memory bus: DMEM_REQ out 1, DMEM_WE out 1, DMEM_ADDR out 32 (word-aligned), DMEM_WDATA out 32, DMEM_BE out 4, DMEM_RDATA in 32, DMEM_ACK in 1.
REQ-004 SHALL have MEM/WB outputs (registered): VALID_MW 1, MEM_DATA_MW 32, PC4_MW 32, RD_MW 5, MemtoReg_MW 2, RegWrite_MW 1.
REQ-005 SHALL have STALL_MEM out 1 (freeze upstream stages) and MISALIGN_MW out 1 (registered exception flag).

Function
REQ-006 SHALL implement FSM states IDLE and WAIT; IDLE->WAIT when VALID_EM & (MemRead_EM|MemWrite_EM) & aligned & !DMEM_ACK; WAIT->IDLE on DMEM_ACK.
REQ-007 SHALL assert DMEM_REQ combinationally in IDLE for an aligned memory op and hold it, with address/data/BE/WE stable, throughout WAIT.
REQ-008 SHALL assert STALL_MEM whenever DMEM_REQ=1 and DMEM_ACK=0; upstream EX/MEM inputs are held stable while stalled.
REQ-009 SHALL drive DMEM_ADDR = {ALU_RES_EM[31:2],2'b00}, DMEM_WE = MemWrite_EM.
REQ-010 SHALL generate stores: SB BE=0001<<addr[1:0], WDATA=byte replicated x4; SH BE=0011<<addr[1:0], WDATA=half replicated x2; SW BE=1111, WDATA=RS2_VAL_EM.
REQ-011 SHALL extract loads from DMEM_RDATA by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-012 SHALL treat misaligned as LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; then no DMEM_REQ, no stall, MISALIGN_MW=1, RegWrite_MW=0.
REQ-013 SHALL load MEM/WB registers on a cycle with no stall: MEM_DATA_MW = extracted load data when MemtoReg_EM=01, else ALU_RES_EM; other fields copied from *_EM.
REQ-014 SHALL produce a bubble (VALID_MW=0, RegWrite_MW=0, MISALIGN_MW=0) in any cycle STALL_MEM=1 or VALID_EM=0.
REQ-015 SHALL give latency of one cycle from ACK (or issue, for non-memory ops) to MEM/WB update; zero-wait ACK in IDLE completes without entering WAIT.
REQ-016 SHALL ignore DMEM_ACK when DMEM_REQ=0.
REQ-017 SHALL force RegWrite_MW=0 when RD_EM=0.

Reset
REQ-018 SHALL, on RST=0, asynchronously set FSM=IDLE and all MEM/WB outputs to 0; DMEM_REQ and STALL_MEM are 0 during reset.
REQ-019 SHALL abandon an outstanding WAIT transaction on reset; a late ACK after reset release is ignored per REQ-016.

Structure
REQ-020 SHALL take FUNCT3 load/store encodings and MemtoReg codes (00 ALU, 01 MEM, 10 PC+4) from the shared package constants.
REQ-021 SHALL place byte-lane store/load alignment in one combinational sub-module lsu_align.

Verification
REQ-022 SB addr=0x103, RS2=0x000000AB, ACK same cycle -> BE=1000, WDATA=0xABABABAB, no stall, VALID_MW=1 next cycle.
REQ-023 LB addr=0x102, RDATA=0x00800000, ACK after 3 cycles -> STALL_MEM 3 cycles, MEM_DATA_MW=0xFFFFFF80, MemtoReg_MW=01.
REQ-024 LHU addr=0x101 -> no DMEM_REQ, MISALIGN_MW=1, RegWrite_MW=0.
REQ-025 JAL (MemtoReg=10, PC4=0x44, RD=1) -> PC4_MW=0x44, RD_MW=1, RegWrite_MW=1 after 1 cycle, DMEM_REQ=0.
REQ-026 LW in WAIT, RST=0 for 1 cycle, ACK 2 cycles later -> outputs 0, FSM IDLE, late ACK causes no MEM/WB update.
